// File: rtl/branch_predict_unit.sv
// Branch resolve and prediction unit: a PC-indexed table of 2-bit saturating
// counters supplies a combinational fetch prediction, and a one-cycle resolve
// path computes the actual outcome, flags mispredicts and trains the table.
module branch_predict_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              fetch_pred_taken,
  input  logic              res_valid,
  input  logic [5:0]        res_opcode,
  input  logic [PC_W-1:0]   res_pc,
  input  logic [DATA_W-1:0] res_rs,
  input  logic [DATA_W-1:0] res_rt,
  input  logic              res_pred_taken,
  output logic              out_valid,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGT  = 6'b000111;
  localparam logic [5:0] OP_BGTE = 6'b000110;
  localparam logic [5:0] OP_BLT  = 6'b000001;
  localparam logic [5:0] OP_BLTE = 6'b011100;
  localparam logic [5:0] OP_BLTU = 6'b011110;
  localparam logic [5:0] OP_BGEU = 6'b011111;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic             out_valid_q, out_valid_d;
  logic             out_taken_q, out_taken_d;
  logic             out_mispredict_q, out_mispredict_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic             is_branch;
  logic             taken;
  logic             op_eq;
  logic             op_slt;
  logic             op_ult;

  // Only word-aligned PC bits select a counter; the rest are deliberately dropped.
  logic unused_pc_parity;
  assign unused_pc_parity = ^{fetch_pc, res_pc};

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign res_idx   = res_pc[IDX_W+1:2];

  // Fetch prediction reads the registered table, so a same-cycle update is not visible.
  assign fetch_pred_taken = bht_q[fetch_idx][1];

  assign out_valid        = out_valid_q;
  assign out_taken        = out_taken_q;
  assign out_mispredict   = out_mispredict_q;
  assign mispredict_count = count_q;

  // Full-width native compares; signed relation uses a true signed compare.
  always_comb begin
    op_eq  = (res_rs == res_rt);
    op_slt = ($signed(res_rs) < $signed(res_rt));
    op_ult = (res_rs < res_rt);
  end

  // Decode opcode into branch/non-branch and the actual outcome.
  always_comb begin
    is_branch = 1'b1;
    taken     = 1'b0;
    case (res_opcode)
      OP_BEQ:  taken = op_eq;
      OP_BNE:  taken = !op_eq;
      OP_BGT:  taken = !op_slt && !op_eq;
      OP_BGTE: taken = !op_slt;
      OP_BLT:  taken = op_slt;
      OP_BLTE: taken = op_slt || op_eq;
      OP_BLTU: taken = op_ult;
      OP_BGEU: taken = !op_ult;
      default: begin
        is_branch = 1'b0;
        taken     = 1'b0;
      end
    endcase
  end

  // Next-state for result registers, mispredict counter and counter table.
  always_comb begin
    out_valid_d      = res_valid;
    out_taken_d      = res_valid && taken;
    out_mispredict_d = res_valid && (taken ^ res_pred_taken);
    count_d          = count_q;
    bht_d            = bht_q;

    if (out_mispredict_d && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end

    if (res_valid && is_branch) begin
      if (taken) begin
        if (bht_q[res_idx] != CTR_STRONG_T) begin
          bht_d[res_idx] = bht_q[res_idx] + 2'd1;
        end
      end else begin
        if (bht_q[res_idx] != CTR_STRONG_NT) begin
          bht_d[res_idx] = bht_q[res_idx] - 2'd1;
        end
      end
    end
  end

  // State registers; synchronous reset wins over any concurrent resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_mispredict_q <= 1'b0;
      count_q          <= '0;
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht_q[i] <= CTR_WEAK_NT;
      end
    end else begin
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_mispredict_q <= out_mispredict_d;
      count_q          <= count_d;
      bht_q            <= bht_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed table of vectors with hand-derived
// expectations, then randomized traffic against a behavioural model. A second
// instance with a 2-bit statistics counter shares the stimulus to cover saturation.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        res_valid;
  logic [5:0]  res_opcode;
  logic [31:0] res_pc;
  logic [31:0] res_rs;
  logic [31:0] res_rt;
  logic        res_pred_taken;

  logic        fpt_a, ov_a, ot_a, om_a;
  logic [15:0] cnt_a;
  logic        fpt_b, ov_b, ot_b, om_b;
  logic [1:0]  cnt_b;

  int vectors    = 0;
  int miscompares = 0;

  // Model state: counter values 0..3 and an unbounded mispredict tally.
  int model_bht [16];
  int model_cnt;

  always #5 clk = ~clk;

  branch_predict_unit #(.DATA_W(32), .PC_W(32), .BHT_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_pred_taken(fpt_a),
    .res_valid(res_valid), .res_opcode(res_opcode), .res_pc(res_pc),
    .res_rs(res_rs), .res_rt(res_rt), .res_pred_taken(res_pred_taken),
    .out_valid(ov_a), .out_taken(ot_a), .out_mispredict(om_a), .mispredict_count(cnt_a)
  );

  branch_predict_unit #(.DATA_W(32), .PC_W(32), .BHT_DEPTH(16), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_pred_taken(fpt_b),
    .res_valid(res_valid), .res_opcode(res_opcode), .res_pc(res_pc),
    .res_rs(res_rs), .res_rt(res_rt), .res_pred_taken(res_pred_taken),
    .out_valid(ov_b), .out_taken(ot_b), .out_mispredict(om_b), .mispredict_count(cnt_b)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        pred;
    logic [31:0] fpc;
    logic        e_fetch;
    logic        e_valid;
    logic        e_taken;
    logic        e_mis;
    int          e_cnt;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic v, logic [5:0] op, logic [31:0] pc,
                              logic [31:0] rs, logic [31:0] rt, logic pred, logic [31:0] fpc,
                              logic ef, logic ev, logic et, logic em, int ec);
    vec_t x;
    x.rst = r; x.valid = v; x.op = op; x.pc = pc; x.rs = rs; x.rt = rt; x.pred = pred;
    x.fpc = fpc; x.e_fetch = ef; x.e_valid = ev; x.e_taken = et; x.e_mis = em; x.e_cnt = ec;
    return x;
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic bit model_is_branch(logic [5:0] op);
    return op == 6'b000100 || op == 6'b000101 || op == 6'b000111 || op == 6'b000110 ||
           op == 6'b000001 || op == 6'b011100 || op == 6'b011110 || op == 6'b011111;
  endfunction

  // Outcome from the opcode rules, evaluated on 64-bit integers.
  function automatic bit model_taken(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    case (op)
      6'b000100: return ua == ub;
      6'b000101: return ua != ub;
      6'b000111: return sa > sb;
      6'b000110: return sa >= sb;
      6'b000001: return sa < sb;
      6'b011100: return sa <= sb;
      6'b011110: return ua < ub;
      6'b011111: return !(ua < ub);
      default:   return 1'b0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check prediction mid-cycle, advance model, check registered outputs.
  task automatic run_cycle(input vec_t v, input bit use_tbl);
    bit m_fetch, m_valid, m_taken, m_mis;
    int m_small;
    rst = v.rst; res_valid = v.valid; res_opcode = v.op; res_pc = v.pc;
    res_rs = v.rs; res_rt = v.rt; res_pred_taken = v.pred; fetch_pc = v.fpc;
    #1;
    m_fetch = (model_bht[idx_of(v.fpc)] >= 2);
    chk("fetch_pred", {31'd0, fpt_a}, {31'd0, m_fetch});
    chk("fetch_pred_small", {31'd0, fpt_b}, {31'd0, m_fetch});
    if (use_tbl) chk("fetch_pred_tbl", {31'd0, fpt_a}, {31'd0, v.e_fetch});

    m_valid = 1'b0; m_taken = 1'b0; m_mis = 1'b0;
    if (v.rst) begin
      for (int i = 0; i < 16; i++) model_bht[i] = 1;
      model_cnt = 0;
    end else if (v.valid) begin
      m_valid = 1'b1;
      m_taken = model_taken(v.op, v.rs, v.rt);
      m_mis   = m_taken ^ v.pred;
      if (m_mis) model_cnt++;
      if (model_is_branch(v.op)) begin
        if (m_taken) model_bht[idx_of(v.pc)] = (model_bht[idx_of(v.pc)] == 3) ? 3 : model_bht[idx_of(v.pc)] + 1;
        else         model_bht[idx_of(v.pc)] = (model_bht[idx_of(v.pc)] == 0) ? 0 : model_bht[idx_of(v.pc)] - 1;
      end
    end
    m_small = (model_cnt > 3) ? 3 : model_cnt;

    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, ov_a}, {31'd0, m_valid});
    chk("out_valid_small", {31'd0, ov_b}, {31'd0, m_valid});
    if (m_valid) begin
      chk("out_taken", {31'd0, ot_a}, {31'd0, m_taken});
      chk("out_mispredict", {31'd0, om_a}, {31'd0, m_mis});
      chk("out_mispredict_small", {31'd0, om_b}, {31'd0, m_mis});
    end
    if (v.rst) begin
      chk("reset_taken", {31'd0, ot_a}, 32'd0);
      chk("reset_mispredict", {31'd0, om_a}, 32'd0);
    end
    chk("mispredict_count", {16'd0, cnt_a}, (model_cnt > 65535) ? 32'd65535 : 32'(model_cnt));
    chk("mispredict_count_small", {30'd0, cnt_b}, 32'(m_small));
    if (use_tbl) begin
      chk("out_valid_tbl", {31'd0, ov_a}, {31'd0, v.e_valid});
      if (v.e_valid) begin
        chk("out_taken_tbl", {31'd0, ot_a}, {31'd0, v.e_taken});
        chk("out_mispredict_tbl", {31'd0, om_a}, {31'd0, v.e_mis});
      end
      chk("count_tbl", {16'd0, cnt_a}, 32'(v.e_cnt));
      chk("count_small_tbl", {30'd0, cnt_b}, 32'((v.e_cnt > 3) ? 3 : v.e_cnt));
    end
  endtask

  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BGT = 6'b000111;
  localparam logic [5:0] BLT = 6'b000001, BGEU = 6'b011111, NOBR = 6'b100011;

  initial begin
    vec_t idle;
    logic [5:0] ops [10];
    for (int i = 0; i < 16; i++) model_bht[i] = 1;
    model_cnt = 0;

    // Two reset cycles bring both instances to a known state.
    rst = 1'b1; res_valid = 1'b0; res_opcode = '0; res_pc = '0;
    res_rs = '0; res_rt = '0; res_pred_taken = 1'b0; fetch_pc = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, ov_a}, 32'd0);
    chk("rst_count", {16'd0, cnt_a}, 32'd0);
    chk("rst_count_small", {30'd0, cnt_b}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      fetch_pc = 32'(i * 4); #1;
      chk("rst_fetch_pred", {31'd0, fpt_a}, 32'd0);
    end

    //          rst  v  op    pc          rs            rt            pr fpc         ef ev et em cnt
    tbl.push_back(mk(0, 1, BEQ,  32'h40, 32'd5,        32'd5,        0, 32'h40, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, BEQ,  32'h40, 32'd0,        32'd0,        0, 32'h40, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, BGT,  32'h44, 32'h80000000, 32'h7FFFFFFF, 0, 32'h44, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, BGEU, 32'h48, 32'h80000000, 32'h7FFFFFFF, 1, 32'h48, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, BEQ,  32'h0,  32'd0,        32'd0,        0, 32'h48, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, BEQ,  32'h4C, 32'd1,        32'd1,        0, 32'h4C, 0, 1, 1, 1, 2));
    tbl.push_back(mk(0, 0, BEQ,  32'h0,  32'd0,        32'd0,        0, 32'h4C, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, BEQ,  32'h14, 32'd7,        32'd7,        1, 32'h14, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, BEQ,  32'h14, 32'd7,        32'd7,        1, 32'h14, 1, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, BEQ,  32'h14, 32'd7,        32'd7,        1, 32'h14, 1, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, BEQ,  32'h14, 32'd7,        32'd7,        1, 32'h14, 1, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, BNE,  32'h14, 32'd9,        32'd9,        1, 32'h14, 1, 1, 0, 1, 3));
    tbl.push_back(mk(0, 1, BNE,  32'h14, 32'd9,        32'd9,        1, 32'h14, 1, 1, 0, 1, 4));
    tbl.push_back(mk(0, 0, BEQ,  32'h0,  32'd0,        32'd0,        0, 32'h14, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, NOBR, 32'h40, 32'd3,        32'd3,        1, 32'h40, 1, 1, 0, 1, 5));
    tbl.push_back(mk(0, 0, BEQ,  32'h0,  32'd0,        32'd0,        0, 32'h40, 1, 0, 0, 0, 5));
    tbl.push_back(mk(0, 1, BLT,  32'h50, 32'hFFFFFFFF, 32'd0,        1, 32'h50, 0, 1, 1, 0, 5));
    tbl.push_back(mk(1, 1, BEQ,  32'h40, 32'd5,        32'd5,        0, 32'h40, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, BEQ,  32'h0,  32'd0,        32'd0,        0, 32'h40, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, BEQ,  32'h0,  32'd0,        32'd0,        0, 32'h14, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run_cycle(tbl[i], 1'b1);

    // Randomized traffic checked against the model.
    ops[0] = 6'b000100; ops[1] = 6'b000101; ops[2] = 6'b000111; ops[3] = 6'b000110;
    ops[4] = 6'b000001; ops[5] = 6'b011100; ops[6] = 6'b011110; ops[7] = 6'b011111;
    ops[8] = 6'b100011; ops[9] = 6'b000000;
    for (int n = 0; n < 3000; n++) begin
      idle = mk(0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle.rst   = ($urandom_range(0, 199) == 0);
      idle.valid = ($urandom_range(0, 3) != 0);
      idle.op    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      idle.pc    = $urandom;
      idle.rs    = $urandom;
      case ($urandom_range(0, 7))
        0, 1: idle.rt = idle.rs;
        2:    idle.rt = 32'h7FFFFFFF;
        3:    idle.rt = 32'h80000000;
        default: idle.rt = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) idle.rs = 32'h80000000;
      idle.pred  = 1'($urandom);
      idle.fpc   = ($urandom_range(0, 1) == 0) ? idle.pc : 32'($urandom);
      run_cycle(idle, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
